// File: rtl/bus_arbiter.sv
// Two-master arbiter for a single shared address-decoding bus.
// One transaction is in flight at a time: IDLE -> ACCESS (ACCESS_CYCLES cycles) -> DONE -> IDLE.
// The winner's operation, address and write data are latched at grant time, so master-side
// changes during ACCESS/DONE never reach the bus.
// Build option: define ARBITER_ROUND_ROBIN_EN to alternate grants on simultaneous requests;
// without it master 0 always wins ties (fixed priority).
module bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // Master 0
  input  logic        m0_read_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_address_i,
  input  logic [31:0] m0_write_data_i,
  output logic [31:0] m0_read_data_o,
  output logic        m0_ack_o,
  // Master 1
  input  logic        m1_read_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_address_i,
  input  logic [31:0] m1_write_data_i,
  output logic [31:0] m1_read_data_o,
  output logic        m1_ack_o,
  // Shared bus
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic [31:0] bus_address_o,
  output logic [31:0] bus_write_data_o,
  input  logic [31:0] bus_read_data_i,
  // Status
  output logic        owner_o,
  output logic        busy_o
);

  // Counter wide enough to hold ACCESS_CYCLES-1; at least one bit.
  localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rsp_q, rsp_d;

  logic            m0_req, m1_req;
  logic            grant;  // 0: master 0 wins, 1: master 1 wins

  // Request decode and arbitration between the two masters.
  always_comb begin
    m0_req = m0_read_i | m0_write_i;
    m1_req = m1_read_i | m1_write_i;
    grant  = 1'b0;
    if (m0_req && m1_req) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      // Hand the tie to whoever did not win last time; last_grant resets to 1 so
      // the first tie goes to master 0.
      grant = ~last_grant_q;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = m1_req;
    end
  end

  // Next-state logic: grant/latch in IDLE, count down in ACCESS, single-cycle DONE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_d        = rsp_q;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          state_d      = StAccess;
          owner_d      = grant;
          last_grant_d = grant;
          // Read and write together are treated as a write.
          wr_d         = grant ? m1_write_i      : m0_write_i;
          addr_d       = grant ? m1_address_i    : m0_address_i;
          wdata_d      = grant ? m1_write_data_i : m0_write_data_i;
          cnt_d        = CntLoad;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Capture on the last bus cycle; writes return zero.
          rsp_d   = wr_q ? 32'h0 : bus_read_data_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rsp_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_q        <= rsp_d;
    end
  end

  // Outputs: bus driven only from latched values in ACCESS; ack/read data only in DONE.
  always_comb begin
    bus_read_o       = 1'b0;
    bus_write_o      = 1'b0;
    bus_address_o    = 32'h0;
    bus_write_data_o = 32'h0;
    m0_ack_o         = 1'b0;
    m1_ack_o         = 1'b0;
    m0_read_data_o   = 32'h0;
    m1_read_data_o   = 32'h0;
    busy_o           = (state_q != StIdle);
    owner_o          = owner_q;

    if (state_q == StAccess) begin
      bus_read_o       = ~wr_q;
      bus_write_o      = wr_q;
      bus_address_o    = addr_q;
      bus_write_data_o = wdata_q;
    end

    if (state_q == StDone) begin
      if (owner_q) begin
        m1_ack_o       = 1'b1;
        m1_read_data_o = wr_q ? 32'h0 : rsp_q;
      end else begin
        m0_ack_o       = 1'b1;
        m0_read_data_o = wr_q ? 32'h0 : rsp_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: two master drivers, a transaction-level reference model
// that predicts grants and completions, and a negedge monitor that checks every output.
module tb_bus_arbiter;

  localparam int unsigned AC        = 3;
  localparam int unsigned WaitLimit = 400;
`ifdef ARBITER_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        rd[2];
  logic        wr[2];
  logic [31:0] addr[2];
  logic [31:0] wd[2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        bus_read, bus_write;
  logic [31:0] bus_address, bus_wdata, bus_rdata;
  logic        owner, busy;

  always #5 clk = ~clk;

  bus_arbiter #(
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .m0_read_i       (rd[0]),
    .m0_write_i      (wr[0]),
    .m0_address_i    (addr[0]),
    .m0_write_data_i (wd[0]),
    .m0_read_data_o  (m0_rdata),
    .m0_ack_o        (m0_ack),
    .m1_read_i       (rd[1]),
    .m1_write_i      (wr[1]),
    .m1_address_i    (addr[1]),
    .m1_write_data_i (wd[1]),
    .m1_read_data_o  (m1_rdata),
    .m1_ack_o        (m1_ack),
    .bus_read_o      (bus_read),
    .bus_write_o     (bus_write),
    .bus_address_o   (bus_address),
    .bus_write_data_o(bus_wdata),
    .bus_read_data_i (bus_rdata),
    .owner_o         (owner),
    .busy_o          (busy)
  );

  // Bus slave: read data depends on address and on the cycle, so capture timing matters.
  logic [31:0] salt = 32'h0;
  assign bus_rdata = bus_address ^ salt;

  function automatic logic [31:0] mix(input int unsigned n);
    return (n * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
  endfunction

  typedef struct {
    int unsigned at;     // edge index whose following cycle carries the ack
    bit          m;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned edge_n   = 0;
  int unsigned neg_n    = 0;
  int unsigned free_edge = 0;
  int unsigned mdl_start = 0;
  bit          mdl_active = 1'b0;
  bit          mdl_wr     = 1'b0;
  bit          mdl_owner  = 1'b0;
  bit          mdl_last   = 1'b1;
  logic [31:0] mdl_addr   = 32'h0;
  logic [31:0] mdl_wdata  = 32'h0;
  bit          chk_en     = 1'b0;
  bit          stop       = 1'b0;
  bit          r0, r1, in_acc, in_done, e_ack0, e_ack1;
  int          w;
  logic [31:0] e_rd0, e_rd1;
  exp_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, neg_n, act, exp);
    end
  endtask

  // Reference model: at each sampling edge decide whether a transaction starts and predict it.
  initial forever begin
    @(posedge clk);
    edge_n++;
    r0 = rd[0] | wr[0];
    r1 = rd[1] | wr[1];
    if (reset_i) begin
      chk_en     = 1'b1;
      mdl_active = 1'b0;
      mdl_owner  = 1'b0;
      mdl_last   = 1'b1;
      free_edge  = edge_n + 1;
      exp_q.delete();
    end else if (edge_n >= free_edge && (r0 || r1)) begin
      if (r0 && r1) w = RoundRobin ? int'(!mdl_last) : 0;
      else          w = r1 ? 1 : 0;
      mdl_wr     = wr[w];
      mdl_addr   = addr[w];
      mdl_wdata  = wd[w];
      mdl_owner  = (w == 1);
      mdl_last   = mdl_owner;
      mdl_start  = edge_n;
      mdl_active = 1'b1;
      free_edge  = edge_n + AC + 2;
      e.at    = edge_n + AC;
      e.m     = mdl_owner;
      e.rdata = mdl_wr ? 32'h0 : (mdl_addr ^ mix(edge_n + AC - 1));
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every DUT output once per cycle against the model's prediction.
  initial forever begin
    @(negedge clk);
    neg_n = edge_n;
    if (chk_en) begin
      in_acc  = mdl_active && neg_n >= mdl_start && neg_n < mdl_start + AC;
      in_done = mdl_active && neg_n == mdl_start + AC;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
      if (exp_q.size() > 0 && exp_q[0].at == neg_n) begin
        if (exp_q[0].m) begin e_ack1 = 1'b1; e_rd1 = exp_q[0].rdata; end
        else            begin e_ack0 = 1'b1; e_rd0 = exp_q[0].rdata; end
        void'(exp_q.pop_front());
      end
      chk("busy",        32'(busy),      32'(in_acc || in_done));
      chk("owner",       32'(owner),     32'(mdl_owner));
      chk("bus_read",    32'(bus_read),  32'(in_acc && !mdl_wr));
      chk("bus_write",   32'(bus_write), 32'(in_acc && mdl_wr));
      chk("bus_address", bus_address,    in_acc ? mdl_addr : 32'h0);
      if (!(in_acc && !mdl_wr)) chk("bus_write_data", bus_wdata, in_acc ? mdl_wdata : 32'h0);
      chk("m0_ack",       32'(m0_ack), 32'(e_ack0));
      chk("m1_ack",       32'(m1_ack), 32'(e_ack1));
      chk("m0_read_data", m0_rdata,    e_rd0);
      chk("m1_read_data", m1_rdata,    e_rd1);
    end
    salt = mix(neg_n);
  end

  // Master driver: random op, hold until ack, sometimes scramble inputs while in flight.
  task automatic drive(input int m);
    int unsigned waited;
    int unsigned op;
    bit          got;
    forever begin
      if (stop) return;
      op      = $urandom_range(0, 2);
      rd[m]   = (op != 1);
      wr[m]   = (op != 0);
      addr[m] = $urandom;
      wd[m]   = $urandom;
      waited  = 0;
      got     = 1'b0;
      while (!got) begin
        @(negedge clk);
        got = (m == 0) ? m0_ack : m1_ack;
        if (!got) begin
          waited++;
          if (waited > WaitLimit) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_timeout master %0d: got no ack after %0d cycles, required ack",
                     m, waited);
            got = 1'b1;
          end else begin
            @(posedge clk);
            #1;
            if (mdl_active && mdl_owner == (m == 1) && edge_n <= mdl_start + AC &&
                $urandom_range(0, 1) == 1) begin
              addr[m] = $urandom;
              wd[m]   = $urandom;
            end
          end
        end
      end
      @(posedge clk);
      #1;
      rd[m] = 1'b0;
      wr[m] = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int unsigned tries;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    fork
      drive(0);
      drive(1);
    join_none
    // Traffic with resets landing in the middle of ACCESS.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(200, 400)) @(posedge clk);
      tries = 0;
      do begin
        @(posedge clk);
        #1;
        tries++;
      end while (!(mdl_active && edge_n == mdl_start) && tries < 50);
      reset_i = 1'b1;
      @(posedge clk);
      #1 reset_i = 1'b0;
    end
    repeat (400) @(posedge clk);
    stop = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("pending_acks", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 1, number of cycles (>=1) a granted transaction holds the shared bus.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_read, m0_write  input  1 each  master 0 request strobes; held until m0_ack.
REQ-005 m0_address, m0_write_data  input  32 each  master 0 address/write data; stable while requesting.
REQ-006 m0_read_data  output  32  master 0 returned read data; valid only while m0_ack=1.
REQ-007 m0_ack  output  1  one-cycle completion pulse to master 0.
REQ-008 m1_read, m1_write, m1_address, m1_write_data, m1_read_data, m1_ack  same directions/widths/meaning for master 1.
REQ-009 bus_read, bus_write  output  1 each  strobes to the shared address-decoding bus.
REQ-010 bus_address, bus_write_data  output  32 each  address/data to the shared bus.
REQ-011 bus_read_data  input  32  read data returned by the bus.
REQ-012 owner  output  1  master currently granted (0/1); busy  output  1  high in any state except IDLE.

Function
REQ-013 FSM states IDLE, ACCESS, DONE; one transaction in flight at a time.
REQ-014 IDLE: request = read|write; if no master requests, stay IDLE; else latch winner's op, address, write data, set owner, load access counter with ACCESS_CYCLES-1, go ACCESS.
REQ-015 Read and write both high from one master: treated as a write; bus_read stays 0.
REQ-016 ACCESS: bus_read/bus_write/bus_address/bus_write_data driven from latched registers only; counter decrements each cycle; on counter=0 capture bus_read_data (reads) into response register, go DONE.
REQ-017 DONE: assert ack of owner for exactly one cycle, other ack 0; owner's read_data = captured value for reads, 0 for writes; go IDLE unconditionally.
REQ-018 Outside ACCESS all bus_* outputs are 0; non-owner read_data always 0; read_data 0 whenever ack=0.
REQ-019 Latency: request sampled in IDLE cycle T -> ack in cycle T+ACCESS_CYCLES+1; next grant earliest at T+ACCESS_CYCLES+2.
REQ-020 Masters deassert or change request at the edge that samples ack=1; a request still high in the following IDLE is a new transaction.
REQ-021 Request changes during ACCESS/DONE are ignored; latched values govern the bus.
REQ-022 Tie rule (both request in IDLE) per REQ-026/027; a lone requester is always granted.
REQ-023 last_grant register updates to owner on each IDLE->ACCESS transition.

Reset
REQ-024 reset=1 at an edge forces IDLE, owner=0, last_grant=1, counter=0, response register 0, all acks, read_data and bus_* outputs 0, busy=0, regardless of state.
REQ-025 Transaction interrupted by reset is abandoned with no ack; master must re-request.

Configuration
REQ-026 Macro ARBITER_ROUND_ROBIN_EN defined: on tie, grant the master not equal to last_grant (first tie after reset goes to master 0).
REQ-027 Macro undefined: fixed priority, master 0 always wins ties; last_grant kept but unused for arbitration.

Verification
REQ-028 Reset mid-ACCESS: reset at ACCESS cycle -> next cycle IDLE, busy=0, bus_*=0, no ack ever issued for that transaction.
REQ-029 m0 read 0x00000010, bus_read_data=0xCAFEBABE, ACCESS_CYCLES=1 -> bus_read=1 in cycle T+1, m0_ack=1 with m0_read_data=0xCAFEBABE in T+2 only.
REQ-030 m1 write 0x00002001 data 0x0000005A -> bus_write=1, bus_address=0x00002001, bus_write_data=0x5A for one cycle; m1_ack at T+2, m1_read_data=0.
REQ-031 Both masters continuous requests, round-robin build -> grants alternate 0,1,0,1 every 3 cycles; fixed build -> master 0 granted every time, m1 never acked.
REQ-032 ACCESS_CYCLES=3, m0 read -> bus_read high exactly 3 cycles, data captured on third, m0_ack at T+4; m0_address change during ACCESS does not alter bus_address.
REQ-033 m0 read+write both high at 0x00000004 -> bus_write=1, bus_read=0, m0_read_data=0 on ack.
